// File: rtl/pg_carry_sum_serial_if.sv
// Nibble-stream / result handshake bundle for the serial PG carry-sum unit.
// Master drives nibbles and result acceptance; slave is the adder.
interface pg_carry_sum_serial_if #(
    parameter int NIBBLES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             p;
    logic [3:0]             g;
    logic                   first;
    logic                   sub;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NIBBLES-1:0]   sum;
    logic                   cout;
    logic                   ovf;
    logic                   err;

    modport master (
        output in_valid, p, g, first, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, err
    );

    modport slave (
        input  in_valid, p, g, first, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, err
    );
endinterface

// File: rtl/pg_carry_sum_serial.sv
// Serial carry-lookahead adder back end: consumes per-nibble propagate/generate
// LSB first, chains the carry and returns sum, carry-out and signed overflow.
module pg_carry_sum_serial #(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pg_carry_sum_serial_if.slave    bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic            carry_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            ovf_q;
    logic            err_q;

    logic            accept;
    logic            last_nib;
    logic [4:0]      c;
    logic [3:0]      s;

    assign accept   = bus.in_valid && (state_q != DONE);
    assign last_nib = (count_q == CW'(NIBBLES - 1));

    // Two-level lookahead inside the nibble; only the nibble carry is chained.
    always_comb begin
        c    = '0;
        c[0] = bus.first ? bus.sub : carry_q;
        c[1] = bus.g[0] | (bus.p[0] & c[0]);
        c[2] = bus.g[1] | (bus.p[1] & bus.g[0]) | (bus.p[1] & bus.p[0] & c[0]);
        c[3] = bus.g[2] | (bus.p[2] & bus.g[1]) | (bus.p[2] & bus.p[1] & bus.g[0])
             | (bus.p[2] & bus.p[1] & bus.p[0] & c[0]);
        c[4] = bus.g[3] | (bus.p[3] & bus.g[2]) | (bus.p[3] & bus.p[2] & bus.g[1])
             | (bus.p[3] & bus.p[2] & bus.p[1] & bus.g[0])
             | (bus.p[3] & bus.p[2] & bus.p[1] & bus.p[0] & c[0]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sum_bit
            assign s[gi] = bus.p[gi] ^ c[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        if (bus.first) begin
                            // A first nibble always starts fresh, aborting any partial op.
                            sum_q[3:0] <= s;
                            carry_q    <= c[4];
                            count_q    <= CW'(1);
                            if (NIBBLES == 1) begin
                                cout_q  <= c[4];
                                ovf_q   <= c[3] ^ c[4];
                                state_q <= DONE;
                            end else begin
                                state_q <= ACC;
                            end
                        end else if (state_q == ACC) begin
                            sum_q[count_q*4 +: 4] <= s;
                            carry_q               <= c[4];
                            count_q               <= count_q + CW'(1);
                            if (last_nib) begin
                                cout_q  <= c[4];
                                ovf_q   <= c[3] ^ c[4];
                                state_q <= DONE;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q != DONE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
endmodule
